// File: rtl/vga_sync_gen.sv
// vga_sync_gen: free-running VGA timing generator (i_Clk/i_Rst/i_En in; registered sync, active, col/row counts and line/frame strobes out)
module vga_sync_gen #(
  parameter int   c_ACTIVE_COLS = 640,
  parameter int   c_H_FRONT     = 16,
  parameter int   c_H_SYNC      = 96,
  parameter int   c_H_BACK      = 48,
  parameter int   c_ACTIVE_ROWS = 480,
  parameter int   c_V_FRONT     = 10,
  parameter int   c_V_SYNC      = 2,
  parameter int   c_V_BACK      = 33,
  parameter logic c_SYNC_POL    = 1'b0
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_En,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic       o_Active,
  output logic [9:0] o_Col_Count,
  output logic [9:0] o_Row_Count,
  output logic       o_Line_Start,
  output logic       o_Frame_Start
);
  localparam int TOTAL_COLS = c_ACTIVE_COLS + c_H_FRONT + c_H_SYNC + c_H_BACK;
  localparam int TOTAL_ROWS = c_ACTIVE_ROWS + c_V_FRONT + c_V_SYNC + c_V_BACK;
  localparam logic [9:0] LAST_COL = 10'(TOTAL_COLS - 1);
  localparam logic [9:0] LAST_ROW = 10'(TOTAL_ROWS - 1);
  localparam logic [9:0] H_FP = 10'(c_ACTIVE_COLS);
  localparam logic [9:0] H_SP = 10'(c_ACTIVE_COLS + c_H_FRONT);
  localparam logic [9:0] H_BP = 10'(c_ACTIVE_COLS + c_H_FRONT + c_H_SYNC);
  localparam logic [9:0] V_FP = 10'(c_ACTIVE_ROWS);
  localparam logic [9:0] V_SP = 10'(c_ACTIVE_ROWS + c_V_FRONT);
  localparam logic [9:0] V_BP = 10'(c_ACTIVE_ROWS + c_V_FRONT + c_V_SYNC);

  typedef enum logic [1:0] {H_ACTIVE, H_FRONT, H_SYNC, H_BACK} h_t;
  typedef enum logic [1:0] {V_ACTIVE, V_FRONT, V_SYNC, V_BACK} v_t;

  h_t         h_state, h_nxt;
  v_t         v_state, v_nxt;
  logic [9:0] col_nxt, row_nxt;
  logic       col_wrap, hsync_nxt, vsync_nxt, active_nxt, line_nxt, frame_nxt;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_Col_Count   <= LAST_COL;
      o_Row_Count   <= LAST_ROW;
      h_state       <= H_BACK;
      v_state       <= V_BACK;
      o_HSync       <= ~c_SYNC_POL;
      o_VSync       <= ~c_SYNC_POL;
      o_Active      <= 1'b0;
      o_Line_Start  <= 1'b0;
      o_Frame_Start <= 1'b0;
    end else begin
      o_Col_Count   <= col_nxt;
      o_Row_Count   <= row_nxt;
      h_state       <= h_nxt;
      v_state       <= v_nxt;
      o_HSync       <= hsync_nxt;
      o_VSync       <= vsync_nxt;
      o_Active      <= active_nxt;
      o_Line_Start  <= line_nxt;
      o_Frame_Start <= frame_nxt;
    end
  end

  // phases decode from the next counts (descending order tolerates zero-width porches)
  always_comb begin
    col_wrap = o_Col_Count >= LAST_COL;
    col_nxt  = !i_En ? o_Col_Count : col_wrap ? '0 : o_Col_Count + 10'd1;
    row_nxt  = !(i_En && col_wrap) ? o_Row_Count : (o_Row_Count >= LAST_ROW) ? '0 : o_Row_Count + 10'd1;
    h_nxt    = !i_En ? h_state : col_nxt >= H_BP ? H_BACK : col_nxt >= H_SP ? H_SYNC : col_nxt >= H_FP ? H_FRONT : H_ACTIVE;
    v_nxt    = !i_En ? v_state : row_nxt >= V_BP ? V_BACK : row_nxt >= V_SP ? V_SYNC : row_nxt >= V_FP ? V_FRONT : V_ACTIVE;
  end

  always_comb begin
    hsync_nxt  = (h_nxt == H_SYNC) ? c_SYNC_POL : ~c_SYNC_POL;
    vsync_nxt  = (v_nxt == V_SYNC) ? c_SYNC_POL : ~c_SYNC_POL;
    active_nxt = (col_nxt < H_FP) && (row_nxt < V_FP);
    line_nxt   = i_En && (col_nxt == '0);
    frame_nxt  = line_nxt && (row_nxt == '0);
  end
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed checks of default, narrow-line and tiny inverted-polarity timing instances
module tb_vga_sync_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  int checks = 0;
  int errors = 0;

  logic       d_hs, d_vs, d_act, d_ls, d_fs;
  logic [9:0] d_col, d_row;
  logic       v_hs, v_vs, v_act, v_ls, v_fs;
  logic [9:0] v_col, v_row;
  logic       s_hs, s_vs, s_act, s_ls, s_fs;
  logic [9:0] s_col, s_row;

  always #5 clk = ~clk;

  vga_sync_gen u_def (
    .i_Clk(clk), .i_Rst(rst), .i_En(en),
    .o_HSync(d_hs), .o_VSync(d_vs), .o_Active(d_act),
    .o_Col_Count(d_col), .o_Row_Count(d_row),
    .o_Line_Start(d_ls), .o_Frame_Start(d_fs)
  );

  vga_sync_gen #(
    .c_ACTIVE_COLS(4), .c_H_FRONT(1), .c_H_SYNC(2), .c_H_BACK(1)
  ) u_vert (
    .i_Clk(clk), .i_Rst(rst), .i_En(en),
    .o_HSync(v_hs), .o_VSync(v_vs), .o_Active(v_act),
    .o_Col_Count(v_col), .o_Row_Count(v_row),
    .o_Line_Start(v_ls), .o_Frame_Start(v_fs)
  );

  vga_sync_gen #(
    .c_ACTIVE_COLS(4), .c_H_FRONT(1), .c_H_SYNC(2), .c_H_BACK(1),
    .c_ACTIVE_ROWS(3), .c_V_FRONT(1), .c_V_SYNC(1), .c_V_BACK(1),
    .c_SYNC_POL(1'b1)
  ) u_small (
    .i_Clk(clk), .i_Rst(rst), .i_En(en),
    .o_HSync(s_hs), .o_VSync(s_vs), .o_Active(s_act),
    .o_Col_Count(s_col), .o_Row_Count(s_row),
    .o_Line_Start(s_ls), .o_Frame_Start(s_fs)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic restart();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(1);
  endtask

  initial begin
    #12;
    chk("rst_col", d_col, 799);
    chk("rst_row", d_row, 524);
    chk("rst_hs", d_hs, 1);
    chk("rst_vs", d_vs, 1);
    chk("rst_act", d_act, 0);
    chk("rst_ls", d_ls, 0);
    chk("rst_fs", d_fs, 0);
    rst = 1'b0;
    en  = 1'b1;
    step(1);
    chk("first_col", d_col, 0);
    chk("first_row", d_row, 0);
    chk("first_fs", d_fs, 1);
    chk("first_ls", d_ls, 1);
    chk("first_act", d_act, 1);
    step(1);
    chk("c1_col", d_col, 1);
    chk("c1_fs", d_fs, 0);
    chk("c1_ls", d_ls, 0);
    step(638);
    chk("c639_act", d_act, 1);
    step(1);
    chk("c640_col", d_col, 640);
    chk("c640_act", d_act, 0);
    chk("c640_hs", d_hs, 1);
    step(15);
    chk("c655_hs", d_hs, 1);
    step(1);
    chk("c656_col", d_col, 656);
    chk("c656_hs", d_hs, 0);
    step(95);
    chk("c751_hs", d_hs, 0);
    step(1);
    chk("c752_hs", d_hs, 1);
    step(47);
    chk("c799_col", d_col, 799);
    chk("c799_row", d_row, 0);
    chk("c799_ls", d_ls, 0);
    step(1);
    chk("wrap_col", d_col, 0);
    chk("wrap_row", d_row, 1);
    chk("wrap_ls", d_ls, 1);
    chk("wrap_fs", d_fs, 0);
    chk("wrap_act", d_act, 1);
    step(3200);
    chk("r5_col", d_col, 0);
    chk("r5_row", d_row, 5);
    chk("r5_ls", d_ls, 1);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("pause_col", d_col, 0);
      chk("pause_row", d_row, 5);
      chk("pause_ls", d_ls, 0);
    end
    en = 1'b1;
    step(1);
    chk("resume_col", d_col, 1);
    chk("resume_row", d_row, 5);
    chk("resume_ls", d_ls, 0);
    step(100);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_col", d_col, 799);
    chk("arst_row", d_row, 524);
    chk("arst_hs", d_hs, 1);
    chk("arst_vs", d_vs, 1);
    chk("arst_act", d_act, 0);
    rst = 1'b0;
    step(1);
    chk("arel_col", d_col, 0);
    chk("arel_row", d_row, 0);
    chk("arel_fs", d_fs, 1);

    restart();
    chk("v0_col", v_col, 0);
    chk("v0_row", v_row, 0);
    chk("v0_fs", v_fs, 1);
    step(3835);
    chk("v479_col", v_col, 3);
    chk("v479_act", v_act, 1);
    step(1);
    chk("v479c4_act", v_act, 0);
    step(4);
    chk("v480_row", v_row, 480);
    chk("v480_act", v_act, 0);
    chk("v480_vs", v_vs, 1);
    step(79);
    chk("v489_col", v_col, 7);
    chk("v489_vs", v_vs, 1);
    step(1);
    chk("v490_row", v_row, 490);
    chk("v490_vs", v_vs, 0);
    step(15);
    chk("v491_col", v_col, 7);
    chk("v491_vs", v_vs, 0);
    step(1);
    chk("v492_row", v_row, 492);
    chk("v492_vs", v_vs, 1);
    step(263);
    chk("v524_col", v_col, 7);
    chk("v524_row", v_row, 524);
    chk("v524_fs", v_fs, 0);
    step(1);
    chk("vwrap_col", v_col, 0);
    chk("vwrap_row", v_row, 0);
    chk("vwrap_fs", v_fs, 1);

    rst = 1'b1;
    step(1);
    chk("s_rst_hs", s_hs, 0);
    chk("s_rst_vs", s_vs, 0);
    chk("s_rst_col", s_col, 7);
    chk("s_rst_row", s_row, 5);
    rst = 1'b0;
    step(1);
    chk("s0_fs", s_fs, 1);
    chk("s0_act", s_act, 1);
    chk("s0_hs", s_hs, 0);
    step(4);
    chk("s4_act", s_act, 0);
    chk("s4_hs", s_hs, 0);
    step(1);
    chk("s5_hs", s_hs, 1);
    step(1);
    chk("s6_hs", s_hs, 1);
    step(1);
    chk("s7_hs", s_hs, 0);
    step(1);
    chk("s_wrap_col", s_col, 0);
    chk("s_wrap_row", s_row, 1);
    chk("s_wrap_ls", s_ls, 1);
    step(24);
    chk("s_r4_row", s_row, 4);
    chk("s_r4_vs", s_vs, 1);
    chk("s_r4_act", s_act, 0);
    step(7);
    chk("s_r4c7_vs", s_vs, 1);
    step(1);
    chk("s_r5_row", s_row, 5);
    chk("s_r5_vs", s_vs, 0);
    step(8);
    chk("s_fwrap_col", s_col, 0);
    chk("s_fwrap_row", s_row, 0);
    chk("s_fwrap_fs", s_fs, 1);
    chk("s_fwrap_act", s_act, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
